// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler: timed A/B/pedestrian phase sequencer for a two-street intersection
// Ports: i_clk clock; i_rstn sync active-low reset; i_TA/i_TB car present on A/B;
//   i_ped_req pedestrian request; o_LA/o_LB lamps (00 green, 01 red, 10 yellow);
//   o_walk walk lamp; o_ped_ack pulse on first WALK cycle; o_phase current state.
// Optional EMERGENCY_PREEMPT_EN adds i_emg / i_emg_dir (0=A, 1=B) preemption.
module traffic_phase_scheduler #(
    parameter int CNT_W      = 6,
    parameter int GREEN_MIN  = 8,
    parameter int GREEN_MAX  = 32,
    parameter int YELLOW_CYC = 3,
    parameter int ALLRED_CYC = 2,
    parameter int WALK_CYC   = 6
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_TA,
    input  logic       i_TB,
    input  logic       i_ped_req,
`ifdef EMERGENCY_PREEMPT_EN
    input  logic       i_emg,
    input  logic       i_emg_dir,
`endif
    output logic [1:0] o_LA,
    output logic [1:0] o_LB,
    output logic       o_walk,
    output logic       o_ped_ack,
    output logic [2:0] o_phase
);
    typedef enum logic [2:0] {AG = 3'd0, AY = 3'd1, R1 = 3'd2, BG = 3'd3, BY = 3'd4, R2 = 3'd5, WALK = 3'd6} state_t;
    localparam logic [CNT_W-1:0] T_GMIN = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] T_GMAX = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] T_Y    = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] T_R    = CNT_W'(ALLRED_CYC - 1);
    localparam logic [CNT_W-1:0] T_W    = CNT_W'(WALK_CYC - 1);
    localparam logic DIR_A = 1'b0;
    localparam logic DIR_B = 1'b1;
    state_t state, state_nxt;
    logic [CNT_W-1:0] timer;
    logic ped_pend, last_dir, last_dir_nxt, a_yield, b_yield, emg_a, emg_b;
`ifdef EMERGENCY_PREEMPT_EN
    assign emg_a = i_emg & ~i_emg_dir;
    assign emg_b = i_emg & i_emg_dir;
`else
    assign emg_a = 1'b0;
    assign emg_b = 1'b0;
`endif
    always_comb begin
        state_nxt    = state;
        last_dir_nxt = last_dir;
        a_yield = timer >= T_GMIN && (i_TB | ped_pend) && (!i_TA || timer >= T_GMAX);
        b_yield = timer >= T_GMIN && (i_TA | ped_pend) && (!i_TB || timer >= T_GMAX);
        case (state)
            AG: state_nxt = (emg_b || (!emg_a && a_yield)) ? AY : AG;
            AY: state_nxt = timer == T_Y ? R1 : AY;
            BG: state_nxt = (emg_a || (!emg_b && b_yield)) ? BY : BG;
            BY: state_nxt = timer == T_Y ? R2 : BY;
            R1: if (timer == T_R) begin
                state_nxt    = emg_b ? BG : emg_a ? AG : ped_pend ? WALK : BG;
                last_dir_nxt = DIR_A;
            end
            R2: if (timer == T_R) begin
                state_nxt    = emg_b ? BG : emg_a ? AG : ped_pend ? WALK : AG;
                last_dir_nxt = DIR_B;
            end
            WALK: state_nxt = (emg_a | emg_b) ? (last_dir == DIR_A ? R1 : R2) :
                              timer == T_W ? (last_dir == DIR_A ? BG : AG) : WALK;
            default: state_nxt = AG;
        endcase
    end
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state    <= AG;
            timer    <= '0;
            ped_pend <= 1'b0;
            last_dir <= DIR_B;
        end else begin
            state    <= state_nxt;
            timer    <= state_nxt != state ? '0 : &timer ? timer : timer + CNT_W'(1);
            last_dir <= last_dir_nxt;
            // entry into WALK wins over a same-cycle request
            ped_pend <= (state_nxt == WALK && state != WALK) ? 1'b0 :
                        (state != WALK && i_ped_req) ? 1'b1 : ped_pend;
        end
    end
    always_comb begin
        o_LA      = state == AG ? 2'b00 : state == AY ? 2'b10 : 2'b01;
        o_LB      = state == BG ? 2'b00 : state == BY ? 2'b10 : 2'b01;
        o_walk    = state == WALK;
        o_ped_ack = state == WALK && timer == '0;
        o_phase   = state;
    end
endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// tb_traffic_phase_scheduler: scoreboard bench with directed phase sequences
module tb_traffic_phase_scheduler;
    localparam logic [2:0] AG = 3'd0, AY = 3'd1, R1 = 3'd2, BG = 3'd3, BY = 3'd4, R2 = 3'd5, WK = 3'd6;
    logic clk = 1'b0, rstn = 1'b0, ta = 1'b0, tb = 1'b0, ped = 1'b0;
`ifdef EMERGENCY_PREEMPT_EN
    logic emg = 1'b0, emg_dir = 1'b0;
`endif
    logic [1:0] la, lb;
    logic walk, ack;
    logic [2:0] phase;
    typedef struct packed {logic [2:0] ph; logic ack;} exp_t;
    exp_t q[$];
    int errors = 0, checks = 0;
    bit armed = 1'b0;
    always #5 clk = ~clk;
    traffic_phase_scheduler dut (
        .i_clk(clk), .i_rstn(rstn), .i_TA(ta), .i_TB(tb), .i_ped_req(ped),
`ifdef EMERGENCY_PREEMPT_EN
        .i_emg(emg), .i_emg_dir(emg_dir),
`endif
        .o_LA(la), .o_LB(lb), .o_walk(walk), .o_ped_ack(ack), .o_phase(phase)
    );
    function automatic logic [4:0] lamps(input logic [2:0] ph);
        case (ph)
            AG: return 5'b00_01_0;
            AY: return 5'b10_01_0;
            R1: return 5'b01_01_0;
            BG: return 5'b01_00_0;
            BY: return 5'b01_10_0;
            R2: return 5'b01_01_0;
            WK: return 5'b01_01_1;
            default: return 5'b11_11_1;
        endcase
    endfunction
    always @(negedge clk) begin
        if (armed) begin
            checks++;
            if ((la !== 2'b01 && lb !== 2'b01) || (walk !== 1'b0 && (la !== 2'b01 || lb !== 2'b01))) begin
                errors++;
                $display("FAIL invariant: LA=%b LB=%b walk=%b", la, lb, walk);
            end
            if (q.size() != 0) begin
                exp_t e;
                logic [8:0] got, want;
                e = q.pop_front();
                got  = {phase, la, lb, walk, ack};
                want = {e.ph, lamps(e.ph), e.ack};
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL outputs @%0t: got phase=%0d LA=%b LB=%b walk=%b ack=%b, want phase=%0d LA=%b LB=%b walk=%b ack=%b",
                             $time, phase, la, lb, walk, ack, e.ph, want[5:4], want[3:2], want[1], want[0]);
                end
            end
        end
    end
    task automatic push(input logic [2:0] ph, input logic a);
        @(posedge clk);
        #1;
        q.push_back('{ph, a});
        armed = 1'b1;
    endtask
    task automatic seg(input logic [2:0] ph, input int n);
        for (int i = 0; i < n; i++) push(ph, 1'b0);
    endtask
    task automatic do_reset();
        rstn = 1'b0;
        push(AG, 1'b0);
        push(AG, 1'b0);
        rstn = 1'b1;
    endtask
    initial begin
        rstn = 1'b0;
        push(AG, 1'b0); push(AG, 1'b0); push(AG, 1'b0);
        rstn = 1'b1;
        seg(AG, 50);
        ta = 1'b1; tb = 1'b1;
        do_reset();
        seg(AG, 31); seg(AY, 3); seg(R1, 2); seg(BG, 32); seg(BY, 3); seg(R2, 2); seg(AG, 5);
        ta = 1'b0; tb = 1'b1;
        do_reset();
        seg(AG, 7); seg(AY, 3); seg(R1, 2); seg(BG, 20);
        ta = 1'b0; tb = 1'b0;
        do_reset();
        push(AG, 1'b0);
        ped = 1'b1;
        push(AG, 1'b0);
        ped = 1'b0;
        seg(AG, 5); seg(AY, 3); seg(R1, 2);
        push(WK, 1'b1); seg(WK, 5);
        seg(BG, 10);
        ta = 1'b0; tb = 1'b1;
        do_reset();
        seg(AG, 7); seg(AY, 3); seg(R1, 2); seg(BG, 10);
        ta = 1'b1; tb = 1'b0; ped = 1'b1;
        push(BY, 1'b0);
        ped = 1'b0;
        push(BY, 1'b0);
        rstn = 1'b0;
        push(AG, 1'b0);
        rstn = 1'b1; ta = 1'b0; tb = 1'b0;
        seg(AG, 20);
`ifdef EMERGENCY_PREEMPT_EN
        do_reset();
        push(AG, 1'b0); push(AG, 1'b0);
        emg = 1'b1; emg_dir = 1'b1;
        push(AY, 1'b0); seg(AY, 2); seg(R1, 2);
        ta = 1'b1;
        seg(BG, 40);
        emg = 1'b0;
        seg(BY, 3); seg(R2, 2); seg(AG, 3);
`endif
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
